bcd_wrap_counter: RTL and testbench

Parametrised two-digit BCD modulo counter with increment, decrement and validated parallel load. It is the general-purpose timekeeping counter for the alarm clock: one instance per field (seconds 00–59, minutes 00–59, hours 00–23 or 01–12, alarm fields). Instances chain through the carry/borrow outputs. Digits are directly displayable on the 7-segment path.

---
 rtl/alarm_pkg.sv | 29 ++
 rtl/bcd_digit.sv | 34 +++
 rtl/bcd_wrap_counter.sv | 134 +++++++++++++
 tb/tb_bcd_wrap_counter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and field limits for the alarm clock timekeeping path.
// Two-digit BCD counts are carried as bcd2_t {tens, units}.
package alarm_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t units;
    } bcd2_t;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HR24_MAX = 23;
    localparam int HR12_MIN = 1;
    localparam int HR12_MAX = 12;

    function automatic bcd2_t to_bcd2(int v);
        bcd2_t r;
        r.tens  = bcd_digit_t'(v / 10);
        r.units = bcd_digit_t'(v % 10);
        return r;
    endfunction

    function automatic logic is_bcd2(bcd2_t v);
        return (v.tens <= 4'd9) && (v.units <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit register: load > inc > dec, wraps 9->0 and 0->9.
// Ports: clk, resetn (async low), inc, dec, load, d -> q, wrap9, wrap0.
module bcd_digit
    import alarm_pkg::*;
#(
    parameter bcd_digit_t RST_VAL = '0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  bcd_digit_t d,
    output bcd_digit_t q,
    output logic       wrap9,
    output logic       wrap0
);

    assign wrap9 = (q == 4'd9);
    assign wrap0 = (q == 4'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= d;
        end else if (inc) begin
            q <= wrap9 ? 4'd0 : q + 4'd1;
        end else if (dec) begin
            q <= wrap0 ? 4'd9 : q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_wrap_counter.sv
// Two-digit BCD modulo counter [MIN_VAL, MAX_VAL] with inc/dec/validated load.
// Ports: clk, resetn, inc, dec, set, set_val -> tens, units, at_max, at_min,
//        carry, borrow (combinational), set_err (registered pulse).
module bcd_wrap_counter
    import alarm_pkg::*;
#(
    parameter int MIN_VAL   = 0,
    parameter int MAX_VAL   = 59,
    parameter int RESET_VAL = MIN_VAL
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       inc,
    input  logic       dec,
    input  logic       set,
    input  logic [7:0] set_val,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       at_max,
    output logic       at_min,
    output logic       carry,
    output logic       borrow,
    output logic       set_err
);

    localparam bcd2_t MIN_BCD = to_bcd2(MIN_VAL);
    localparam bcd2_t MAX_BCD = to_bcd2(MAX_VAL);
    localparam bcd2_t RST_BCD = to_bcd2(RESET_VAL);

    if (MIN_VAL < 0 || MIN_VAL > 98 ||
        MAX_VAL <= MIN_VAL || MAX_VAL > 99 ||
        RESET_VAL < MIN_VAL || RESET_VAL > MAX_VAL) begin : g_bad_params
        $error("bcd_wrap_counter: illegal MIN/MAX/RESET_VAL");
    end

    bcd2_t cnt;
    bcd2_t sv;
    logic  set_ok;
    logic  up;
    logic  dn;
    logic  u_wrap9;
    logic  u_wrap0;
    logic  t_wrap9;
    logic  t_wrap0;
    logic  ld;
    bcd2_t ld_val;
    logic  u_inc;
    logic  u_dec;
    logic  t_inc;
    logic  t_dec;

    assign cnt = '{tens: tens, units: units};
    assign sv  = bcd2_t'(set_val);

    // With both digits valid, BCD ordering equals decimal ordering,
    // so range checks compare the packed BCD values directly.
    assign set_ok = is_bcd2(sv) && (sv >= MIN_BCD) && (sv <= MAX_BCD);

    assign up = inc & ~dec & ~set;
    assign dn = dec & ~inc & ~set;

    assign at_max = (cnt == MAX_BCD);
    assign at_min = (cnt == MIN_BCD);

    assign carry  = resetn & up & at_max;
    assign borrow = resetn & dn & at_min;

    always_comb begin
        ld     = 1'b0;
        ld_val = sv;
        u_inc  = 1'b0;
        u_dec  = 1'b0;
        t_inc  = 1'b0;
        t_dec  = 1'b0;
        if (set) begin
            ld = set_ok;
        end else if (up) begin
            if (at_max) begin
                ld     = 1'b1;
                ld_val = MIN_BCD;
            end else begin
                u_inc = 1'b1;
                t_inc = u_wrap9;
            end
        end else if (dn) begin
            if (at_min) begin
                ld     = 1'b1;
                ld_val = MAX_BCD;
            end else begin
                u_dec = 1'b1;
                t_dec = u_wrap0;
            end
        end
    end

    bcd_digit #(
        .RST_VAL (RST_BCD.units)
    ) u_units (
        .clk    (clk),
        .resetn (resetn),
        .inc    (u_inc),
        .dec    (u_dec),
        .load   (ld),
        .d      (ld_val.units),
        .q      (units),
        .wrap9  (u_wrap9),
        .wrap0  (u_wrap0)
    );

    // Tens wrap flags are unused: the parent's MAX/MIN check always
    // intercepts before the tens digit could roll past 9 or 0.
    bcd_digit #(
        .RST_VAL (RST_BCD.tens)
    ) u_tens (
        .clk    (clk),
        .resetn (resetn),
        .inc    (t_inc),
        .dec    (t_dec),
        .load   (ld),
        .d      (ld_val.tens),
        .q      (tens),
        .wrap9  (t_wrap9),
        .wrap0  (t_wrap0)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            set_err <= 1'b0;
        end else begin
            set_err <= set & ~set_ok;
        end
    end

endmodule

// File: tb/tb_bcd_wrap_counter.sv
// Bench for bcd_wrap_counter: seconds->minutes chain, 12-h and 24-h hours.
// Decimal reference model, directed steps followed by random traffic.
module tb_bcd_wrap_counter;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] inc;
    logic [3:0] dec;
    logic [3:0] set;
    logic [7:0] val [4];
    logic [3:0] ten [4];
    logic [3:0] uni [4];
    logic [3:0] amax;
    logic [3:0] amin;
    logic [3:0] cy;
    logic [3:0] bw;
    logic [3:0] serr;

    int mn [4] = '{0, 0, 1, 0};
    int mx [4] = '{59, 59, 12, 23};
    int rv [4] = '{0, 0, 1, 0};
    int cnt [4];
    bit m_err [4];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_wrap_counter #(.MIN_VAL(0), .MAX_VAL(59)) u_sec (
        .clk(clk), .resetn(resetn), .inc(inc[0]), .dec(dec[0]),
        .set(set[0]), .set_val(val[0]), .tens(ten[0]), .units(uni[0]),
        .at_max(amax[0]), .at_min(amin[0]), .carry(cy[0]),
        .borrow(bw[0]), .set_err(serr[0])
    );

    bcd_wrap_counter #(.MIN_VAL(0), .MAX_VAL(59)) u_min (
        .clk(clk), .resetn(resetn), .inc(cy[0]), .dec(dec[1]),
        .set(set[1]), .set_val(val[1]), .tens(ten[1]), .units(uni[1]),
        .at_max(amax[1]), .at_min(amin[1]), .carry(cy[1]),
        .borrow(bw[1]), .set_err(serr[1])
    );

    bcd_wrap_counter #(.MIN_VAL(1), .MAX_VAL(12)) u_h12 (
        .clk(clk), .resetn(resetn), .inc(inc[2]), .dec(dec[2]),
        .set(set[2]), .set_val(val[2]), .tens(ten[2]), .units(uni[2]),
        .at_max(amax[2]), .at_min(amin[2]), .carry(cy[2]),
        .borrow(bw[2]), .set_err(serr[2])
    );

    bcd_wrap_counter #(.MIN_VAL(0), .MAX_VAL(23)) u_h24 (
        .clk(clk), .resetn(resetn), .inc(inc[3]), .dec(dec[3]),
        .set(set[3]), .set_val(val[3]), .tens(ten[3]), .units(uni[3]),
        .at_max(amax[3]), .at_min(amin[3]), .carry(cy[3]),
        .borrow(bw[3]), .set_err(serr[3])
    );

    function automatic logic [7:0] bcd(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic bit load_ok(logic [7:0] v, int k);
        logic [7:0] t;
        int hi;
        int lo;
        int n;
        t  = v;
        hi = int'(t[7:4]);
        lo = int'(t[3:0]);
        if (hi > 9 || lo > 9) return 1'b0;
        n = hi * 10 + lo;
        return (n >= mn[k]) && (n <= mx[k]);
    endfunction

    function automatic int bcd_to_int(logic [7:0] v);
        logic [7:0] t;
        t = v;
        return int'(t[7:4]) * 10 + int'(t[3:0]);
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        inc = '0;
        dec = '0;
        set = '0;
        for (int k = 0; k < 4; k++) val[k] = 8'h00;
    endtask

    task automatic chk_state(string where);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s count[%0d]", where, k),
                {ten[k], uni[k]}, bcd(cnt[k]));
            chk($sformatf("%s set_err[%0d]", where, k),
                8'(serr[k]), 8'(m_err[k]));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            cnt[k]   = rv[k];
            m_err[k] = 1'b0;
        end
    endtask

    // Called just after a falling edge with inputs driven.
    task automatic tick();
        bit ei [4];
        bit ec [4];
        bit eb [4];
        int nx [4];
        bit ne [4];
        #1;
        for (int k = 0; k < 4; k++) begin
            ei[k] = (k == 1) ? ec[0] : inc[k];
            ec[k] = resetn && ei[k] && !dec[k] && !set[k] && cnt[k] == mx[k];
            eb[k] = resetn && dec[k] && !ei[k] && !set[k] && cnt[k] == mn[k];
            chk($sformatf("carry[%0d]", k), 8'(cy[k]), 8'(ec[k]));
            chk($sformatf("borrow[%0d]", k), 8'(bw[k]), 8'(eb[k]));
            chk($sformatf("at_max[%0d]", k), 8'(amax[k]),
                8'(cnt[k] == mx[k]));
            chk($sformatf("at_min[%0d]", k), 8'(amin[k]),
                8'(cnt[k] == mn[k]));
            nx[k] = cnt[k];
            ne[k] = 1'b0;
            if (set[k]) begin
                if (load_ok(val[k], k)) nx[k] = bcd_to_int(val[k]);
                else ne[k] = 1'b1;
            end else if (ei[k] && !dec[k]) begin
                nx[k] = (cnt[k] == mx[k]) ? mn[k] : cnt[k] + 1;
            end else if (dec[k] && !ei[k]) begin
                nx[k] = (cnt[k] == mn[k]) ? mx[k] : cnt[k] - 1;
            end
        end
        @(posedge clk);
        if (resetn) begin
            for (int k = 0; k < 4; k++) begin
                cnt[k]   = nx[k];
                m_err[k] = ne[k];
            end
        end
        @(negedge clk);
        chk_state("step");
    endtask

    task automatic do_set(int k, logic [7:0] v);
        idle();
        set[k] = 1'b1;
        val[k] = v;
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        tick();
        resetn = 1'b1;
        tick();

        // 60 seconds: 00..59..00, minute cascades 00->01 on the wrap edge.
        for (int i = 0; i < 60; i++) begin
            idle();
            inc[0] = 1'b1;
            tick();
        end

        // 12-hour: 01 -> 12 -> 11 on decrement.
        idle();
        dec[2] = 1'b1;
        tick();
        tick();

        // 24-hour loads: out-of-range, non-BCD, then valid.
        do_set(3, 8'h45);
        do_set(3, 8'h1A);
        do_set(3, 8'h17);
        idle();
        tick();

        // set beats inc; inc+dec holds at max.
        do_set(0, 8'h09);
        idle();
        set[0] = 1'b1;
        val[0] = 8'h30;
        inc[0] = 1'b1;
        tick();
        do_set(0, 8'h59);
        idle();
        inc[0] = 1'b1;
        dec[0] = 1'b1;
        tick();
        idle();
        set[0] = 1'b1;
        val[0] = 8'h59;
        inc[0] = 1'b1;
        tick();
        do_set(2, 8'h00);
        do_set(2, 8'h13);

        // Random traffic on all four counters.
        for (int i = 0; i < 300; i++) begin
            idle();
            for (int k = 0; k < 4; k++) begin
                int r;
                r = int'($urandom_range(0, 9));
                inc[k] = (k != 1) && (r <= 3);
                dec[k] = (r >= 3) && (r <= 5);
                set[k] = (r == 9);
                if ($urandom_range(0, 1) == 1)
                    val[k] = 8'($urandom_range(0, 255));
                else
                    val[k] = bcd(int'($urandom_range(mn[k], mx[k])));
            end
            tick();
        end

        // Asynchronous reset between edges at count 37.
        do_set(0, 8'h37);
        idle();
        inc[0] = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        chk_state("async_rst");
        chk("async_rst carry", 8'(cy[0]), 8'h00);
        @(posedge clk);
        @(negedge clk);
        chk_state("rst_hold");
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            inc[0] = 1'b1;
            tick();
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
